// File: rtl/receptor_teclado_pkg.sv
// -----------------------------------------------------------------------------
// receptor_teclado_pkg
//   Shared definitions for the PS/2 keyboard front end and the key-validation
//   FSM downstream of it.
//   - Scan-code constants (make codes of the keys the system reacts to, plus
//     the break and extended prefixes).
//   - State encodings for the frame receiver and the scan-code decoder.
//   - Odd-parity helper used by the frame receiver.
// -----------------------------------------------------------------------------
package receptor_teclado_pkg;

  localparam logic [7:0] K_BREAK   = 8'hF0;
  localparam logic [7:0] K_EXT     = 8'hE0;
  localparam logic [7:0] K_ENTER   = 8'h5A;
  localparam logic [7:0] K_APAGAR  = 8'h29;
  localparam logic [7:0] K_TEMP    = 8'h2C;
  localparam logic [7:0] K_HUMO    = 8'h33;
  localparam logic [7:0] K_NINGUNA = 8'h00;

  // Frame receiver states
  localparam logic [0:0] INACTIVO = 1'b0;
  localparam logic [0:0] RECIBIR  = 1'b1;

  // Scan-code decoder states
  localparam logic [1:0] ESPERA     = 2'd0;
  localparam logic [1:0] ROMPER     = 2'd1;
  localparam logic [1:0] EXT        = 2'd2;
  localparam logic [1:0] EXT_ROMPER = 2'd3;

  // Odd parity over d0..d7 plus the parity bit: the XOR of all nine is 1.
  function automatic logic paridad_ok(input logic [8:0] datos_par);
    return ^datos_par;
  endfunction

endpackage

// File: rtl/receptor_teclado_rx_trama.sv
// -----------------------------------------------------------------------------
// ps2_rx_trama
//   PS/2 device-to-host frame receiver: input synchroniser, ps2clk glitch
//   filter, 11-bit frame FSM with parity/start/stop checking and a timeout
//   that aborts partial frames.
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   ps2clk       raw PS/2 clock line (asynchronous)
//   ps2data      raw PS/2 data line (asynchronous)
//   dato         received scan code, valid while dato_listo is high
//   dato_listo   1-cycle pulse, the cycle after the stop-bit strobe
//   err          1-cycle pulse on parity, start, stop or timeout error
//   ocupado      high while a frame is being received
// -----------------------------------------------------------------------------
module ps2_rx_trama
  import receptor_teclado_pkg::*;
#(
  parameter int FILTRO_BITS    = 8,
  parameter int TIMEOUT_CICLOS = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] dato,
  output logic       dato_listo,
  output logic       err,
  output logic       ocupado
);

  localparam int FW = $clog2(FILTRO_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  logic          ps2clk_p0, ps2clk_p1;
  logic          ps2data_p0, ps2data_p1;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_clk_p2;
  logic          strobe;
  logic [0:0]    estado;
  logic [3:0]    nbits;
  logic [TW-1:0] to_cnt;
  logic [8:0]    sh;

  // Stage p0/p1: two-flop synchroniser; lines idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2clk_p0  <= 1'b1;
      ps2clk_p1  <= 1'b1;
      ps2data_p0 <= 1'b1;
      ps2data_p1 <= 1'b1;
    end else begin
      ps2clk_p0  <= ps2clk;
      ps2clk_p1  <= ps2clk_p0;
      ps2data_p0 <= ps2data;
      ps2data_p1 <= ps2data_p0;
    end
  end

  // Stage p2: glitch filter. filt_cnt counts consecutive synced samples that
  // disagree with filt_clk; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt    <= '0;
      filt_clk    <= 1'b1;
      filt_clk_p2 <= 1'b1;
    end else begin
      filt_clk_p2 <= filt_clk;
      if (ps2clk_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTRO_BITS - 1)) begin
        filt_clk <= ps2clk_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe  = filt_clk_p2 & ~filt_clk;
  assign ocupado = (estado == RECIBIR);
  assign dato    = sh[7:0];

  // Frame FSM. nbits counts strobes already taken in this frame, so the
  // strobe seen with nbits == 10 is the stop bit. A strobe always wins over
  // a timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= INACTIVO;
      nbits      <= '0;
      to_cnt     <= '0;
      dato_listo <= 1'b0;
      err        <= 1'b0;
    end else begin
      dato_listo <= 1'b0;
      err        <= 1'b0;
      if (strobe || estado == INACTIVO) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;
      case (estado)
        INACTIVO: begin
          if (strobe && !ps2data_p1) begin
            estado <= RECIBIR;
            nbits  <= 4'd1;
          end
        end
        default: begin
          if (strobe) begin
            if (nbits == 4'd10) begin
              estado <= INACTIVO;
              nbits  <= '0;
              if (paridad_ok(sh) && ps2data_p1) dato_listo <= 1'b1;
              else                              err        <= 1'b1;
            end else begin
              nbits <= nbits + 1'b1;
            end
          end else if (to_cnt == TW'(TIMEOUT_CICLOS - 1)) begin
            estado <= INACTIVO;
            nbits  <= '0;
            err    <= 1'b1;
          end
        end
      endcase
    end
  end

  // Data/parity shifter: LSB arrives first, so shift right; after nine
  // shifts sh = {P, d7..d0}. The stop bit is not shifted in.
  always_ff @(posedge clk) begin
    if (strobe && estado == RECIBIR && nbits != 4'd10) sh <= {ps2data_p1, sh[8:1]};
  end

endmodule

// File: rtl/receptor_teclado.sv
// -----------------------------------------------------------------------------
// receptor_teclado
//   PS/2 keyboard front end. Receives frames via ps2_rx_trama, tracks the
//   F0 (break) and E0 (extended) prefixes and presents the make code of the
//   held key as a level on tecla (8'h00 when no key is held).
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   ps2clk       raw PS/2 clock line
//   ps2data      raw PS/2 data line
//   tecla        make code of the held key, 8'h00 = none
//   tecla_nueva  1-cycle pulse aligned with tecla taking a new non-zero value
//   error_trama  1-cycle pulse on a bad or timed-out frame
//   ocupado      high while a frame is being received
// -----------------------------------------------------------------------------
module receptor_teclado
  import receptor_teclado_pkg::*;
#(
  parameter int FILTRO_BITS    = 8,
  parameter int TIMEOUT_CICLOS = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] tecla,
  output logic       tecla_nueva,
  output logic       error_trama,
  output logic       ocupado
);

  logic [7:0] dato;
  logic       dato_listo;
  logic [1:0] dec;

  ps2_rx_trama #(
    .FILTRO_BITS   (FILTRO_BITS),
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .dato      (dato),
    .dato_listo(dato_listo),
    .err       (error_trama),
    .ocupado   (ocupado)
  );

  // Decoder: extended keys are swallowed entirely (make and break), so they
  // never disturb the held standard key. A repeated make of the held key
  // (typematic) produces no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec         <= ESPERA;
      tecla       <= K_NINGUNA;
      tecla_nueva <= 1'b0;
    end else begin
      tecla_nueva <= 1'b0;
      if (dato_listo) begin
        case (dec)
          ESPERA: begin
            if (dato == K_BREAK) begin
              dec <= ROMPER;
            end else if (dato == K_EXT) begin
              dec <= EXT;
            end else if (dato != tecla) begin
              tecla       <= dato;
              tecla_nueva <= (dato != K_NINGUNA);
            end
          end
          ROMPER: begin
            if (dato == tecla) tecla <= K_NINGUNA;
            dec <= ESPERA;
          end
          EXT:     dec <= (dato == K_BREAK) ? EXT_ROMPER : ESPERA;
          default: dec <= ESPERA;
        endcase
      end
    end
  end

endmodule
